// File: rtl/axi_read_dma.sv
// Descriptor-driven AXI4 read DMA: splits a word-count transfer into INCR bursts
// (max MAX_BURST beats, never crossing 4 KiB) and forwards the data as an AXI-Stream.
module axi_read_dma #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          ID_WIDTH   = 8,
    parameter int unsigned ARID_VALUE = 0,
    parameter int          MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [15:0]           desc_len,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            dbg_state
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  run_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [8:0]            beats_q, beats_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  r_hs;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [15:0]           next_rem;
    logic                  unused_in;

    // Burst length limited by words left, MAX_BURST and the next 4 KiB page edge.
    function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [15:0] rem);
        logic [31:0] lim;
        lim = (32'd4096 - (32'(a) & 32'hFFF)) >> BSHIFT;
        if ({16'd0, rem} < lim) lim = {16'd0, rem};
        if (32'(MAX_BURST) < lim) lim = 32'(MAX_BURST);
        return 9'(lim);
    endfunction

    // All channels use valid/ready: a transfer happens on a rising clk edge where
    // both are high; a source holds valid and payload stable until that edge.
    assign m_axi_rready  = (state_q == S_DATA) && (!tvalid_q || m_axis_tready);
    assign r_hs          = m_axi_rready && m_axi_rvalid;
    assign desc_ready    = !rst_n || ((state_q == S_IDLE) && run_q);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign dbg_state     = state_q;
    assign m_axi_arid    = ID_WIDTH'(ARID_VALUE);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(beats_q - 9'd1);
    assign m_axi_arsize  = 3'(BSHIFT);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign unused_in     = ^{m_axi_rid, m_axi_rlast};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        arvalid_d   = arvalid_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        done_d      = done_q;
        error_d     = error_q;
        next_addr   = addr_q + ADDR_WIDTH'(32'(beats_q) << BSHIFT);
        next_rem    = remaining_q - 16'd1;

        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_q && desc_valid) begin
                    addr_d      = desc_addr & ALIGN_MASK;
                    remaining_d = desc_len;
                    error_d     = 1'b0;
                    if (desc_len == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ADDR;
                        arvalid_d  = 1'b1;
                        beats_d    = calc_beats(desc_addr & ALIGN_MASK, desc_len);
                        beat_cnt_d = beats_d;
                    end
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    tvalid_d    = 1'b1;
                    tdata_d     = m_axi_rdata;
                    tlast_d     = (remaining_q == 16'd1);
                    remaining_d = next_rem;
                    beat_cnt_d  = beat_cnt_q - 9'd1;
                    if (m_axi_rresp != 2'b00) error_d = 1'b1;
                    if (beat_cnt_q == 9'd1) begin
                        if (next_rem != 16'd0) begin
                            addr_d     = next_addr;
                            beats_d    = calc_beats(next_addr, next_rem);
                            beat_cnt_d = beats_d;
                            arvalid_d  = 1'b1;
                            state_d    = S_ADDR;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            arvalid_q   <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            arvalid_q   <= arvalid_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule
